vsn_port_driver: RTL and testbench

- Terminal end of a VSN port: launches the incident wave (a) into a network port and collects that port's reflected/transmitted wave (b).
- Takes incident vectors from a ready/valid stream and drives them onto the port. Silence (zero) is driven when no stimulus is available.
- Realigns the network response using a known fixed latency and returns it on an output ready/valid stream through a credit-protected FIFO.
- Sits between DMA/stimulus logic and an S-parameter network block.

---
 rtl/vsn_port_driver.sv | 165 ++++++++++++++++
 tb/tb_vsn_port_driver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vsn_port_driver.sv
// vsn_port_driver: drives incident words onto a VSN port and returns the latency-aligned
// response through a credit-protected FIFO. Define VSN_PORT_DRIVER_ERRCNT_EN to build err_count.
module vsn_port_driver #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned NSAMPLES     = 16,
    parameter int unsigned LATENCY      = 4,
    parameter int unsigned FIFO_DEPTH   = 8,
    localparam int unsigned DW          = NSAMPLES * SAMPLE_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [DW-1:0] port_a,
    input  logic [DW-1:0] port_b,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    input  logic          flush,
    output logic          flush_done,
    output logic [31:0]   err_count
);

    localparam int unsigned CW      = $clog2(FIFO_DEPTH + LATENCY + 1);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] { ST_RUN, ST_FLUSH, ST_DONE } state_e;

    state_e               state_q, state_d;
    logic [DW-1:0]        port_a_q, port_a_d;
    logic                 a_tag_q, a_tag_d;
    logic [LATENCY-1:0]   tag_pipe_q, tag_pipe_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        fifo_count_q, fifo_count_d;
    logic                 s_tready_q, s_tready_d;
    logic                 m_tvalid_q, m_tvalid_d;
    logic [DW-1:0]        m_tdata_q, m_tdata_d;
    logic                 flush_done_q, flush_done_d;
    logic [DW-1:0]        mem_q [FIFO_DEPTH];

    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [CW-1:0]        inflight;
    logic [CW-1:0]        inflight_nxt;
    logic [CW-1:0]        remaining;
    logic [CW:0]          credit_used;

    function automatic logic [CW-1:0] count_tags(input logic head, input logic [LATENCY-1:0] pipe);
        logic [CW-1:0] n;
        n = CW'(head);
        for (int unsigned i = 0; i < LATENCY; i++) begin
            n = n + CW'(pipe[i]);
        end
        return n;
    endfunction

    always_comb begin
        accept = s_tvalid & s_tready_q;
        push   = tag_pipe_q[LATENCY-1];
        pop    = m_tvalid_q & m_tready;

        port_a_d      = accept ? s_tdata : '0;
        a_tag_d       = accept;
        tag_pipe_d    = '0;
        tag_pipe_d[0] = a_tag_q;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_pipe_d[i] = tag_pipe_q[i-1];
        end

        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
        remaining    = fifo_count_q - CW'(pop);

        // Output register mirrors the next head; a push into an otherwise empty
        // FIFO bypasses the memory so it is visible one cycle after the push.
        m_tvalid_d = (fifo_count_d != '0);
        m_tdata_d  = m_tdata_q;
        if (m_tvalid_d) begin
            m_tdata_d = (remaining == '0) ? port_b : mem_q[rd_ptr_d];
        end

        inflight = count_tags(a_tag_q, tag_pipe_q);
        state_d  = state_q;
        unique case (state_q)
            ST_RUN:   if (flush) state_d = ST_FLUSH;
            ST_FLUSH: if ((inflight == '0) && (fifo_count_q == '0)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        flush_done_d = (state_d == ST_DONE);

        inflight_nxt = count_tags(a_tag_d, tag_pipe_d);
        credit_used  = {1'b0, fifo_count_d} + {1'b0, inflight_nxt};
        s_tready_d   = (state_d == ST_RUN) && (credit_used < DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            port_a_q     <= '0;
            a_tag_q      <= 1'b0;
            tag_pipe_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            s_tready_q   <= 1'b0;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            flush_done_q <= 1'b0;
        end else begin
            if (push) begin
                assert ({1'b0, fifo_count_q} < DEPTH_C);
            end
            state_q      <= state_d;
            port_a_q     <= port_a_d;
            a_tag_q      <= a_tag_d;
            tag_pipe_q   <= tag_pipe_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            s_tready_q   <= s_tready_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            flush_done_q <= flush_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= port_b;
        end
    end

    assign s_tready   = s_tready_q;
    assign port_a     = port_a_q;
    assign m_tdata    = m_tdata_q;
    assign m_tvalid   = m_tvalid_q;
    assign flush_done = flush_done_q;

`ifdef VSN_PORT_DRIVER_ERRCNT_EN
    logic [31:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (!push && (port_b != '0) && (err_count_q != '1)) begin
            err_count_d = err_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_count_q <= '0;
        else     err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_vsn_port_driver.sv
// tb_vsn_port_driver: randomized bench; reference model tracks accepted words as an in-order
// response queue with ready times, an outstanding-word credit count and flush completion timing.
`timescale 1ns/1ps
module tb_vsn_port_driver;
    localparam int unsigned SW    = 16;
    localparam int unsigned NS    = 16;
    localparam int unsigned LAT   = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = SW * NS;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic [DW-1:0] s_tdata  = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] port_a;
    logic [DW-1:0] port_b   = '0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          flush    = 1'b0;
    logic          flush_done;
    logic [31:0]   err_count;

    vsn_port_driver #(
        .SAMPLE_WIDTH(SW),
        .NSAMPLES    (NS),
        .LATENCY     (LAT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .port_a    (port_a),
        .port_b    (port_b),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .flush     (flush),
        .flush_done(flush_done),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            ready;
    } resp_t;

    resp_t         rq[$];
    int            cyc         = 0;
    int            outstanding = 0;
    bit            checking    = 1'b0;
    bit            rst_prev    = 1'b0;
    bit            flushing    = 1'b0;
    int            flush_from  = 0;
    int            done_at     = -1;
    bit            last_acc    = 1'b0;
    logic [DW-1:0] last_word   = '0;
    int unsigned   exp_err     = 0;
    logic [DW-1:0] hpa  [LAT+1];
    bit            hdrv [LAT+1];

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < int'(DW / 32); k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // Called just after a rising edge: checks this cycle's outputs, plays the network,
    // drives this cycle's inputs and advances the model to the next cycle.
    task automatic run_cycle(input bit v, input logic [DW-1:0] d, input bit mr,
                             input bit fl, input bit rs, input bit inj);
        bit in_flush, exp_tready, exp_mvalid, acc, pop, start;
        in_flush   = flushing && (cyc >= flush_from);
        exp_tready = !rst_prev && !in_flush && (outstanding < int'(DEPTH));
        exp_mvalid = (rq.size() > 0) && (rq[0].ready <= cyc);

        if (checking) begin
            check("port_a",     port_a, last_acc ? last_word : '0);
            check("s_tready",   DW'(s_tready),   DW'(exp_tready));
            check("m_tvalid",   DW'(m_tvalid),   DW'(exp_mvalid));
            check("flush_done", DW'(flush_done), DW'(cyc == done_at));
            check("err_count",  DW'(err_count),  DW'(exp_err));
            if (exp_mvalid)    check("m_tdata", m_tdata, rq[0].data);
            else if (rst_prev) check("m_tdata_rst", m_tdata, '0);
        end

        // Network: port_b is port_a four cycles back, XOR 1 on driven slots.
        for (int i = LAT; i > 0; i--) begin
            hpa[i]  = hpa[i-1];
            hdrv[i] = hdrv[i-1];
        end
        hpa[0]  = port_a;
        hdrv[0] = last_acc;
        if (!hdrv[LAT] && inj && !rs) begin
            port_b = rand_word() | DW'(1);
`ifdef VSN_PORT_DRIVER_ERRCNT_EN
            exp_err++;
`endif
        end else begin
            port_b = hpa[LAT] ^ (hdrv[LAT] ? DW'(1) : '0);
        end

        s_tvalid = v;
        s_tdata  = d;
        m_tready = mr;
        flush    = fl;
        rst      = rs;

        acc = v && exp_tready;
        pop = exp_mvalid && mr;
        if (rs) begin
            rq.delete();
            outstanding = 0;
            flushing    = 1'b0;
            done_at     = -1;
            last_acc    = 1'b0;
            last_word   = '0;
            exp_err     = 0;
            for (int i = 0; i <= LAT; i++) begin
                hpa[i]  = '0;
                hdrv[i] = 1'b0;
            end
            rst_prev = 1'b1;
            checking = 1'b1;
        end else begin
            if (pop) void'(rq.pop_front());
            if (acc) rq.push_back('{data: d ^ DW'(1), ready: cyc + int'(LAT) + 2});
            start = fl && !flushing;
            if (flushing && (done_at >= 0) && (cyc == done_at)) begin
                flushing = 1'b0;
                done_at  = -1;
            end else if (flushing && (cyc >= flush_from) && (done_at < 0) && (outstanding == 0)) begin
                done_at = cyc + 1;
            end
            if (start) begin
                flushing   = 1'b1;
                flush_from = cyc + 1;
                done_at    = -1;
            end
            outstanding += int'(acc) - int'(pop);
            last_acc  = acc;
            last_word = d;
            rst_prev  = 1'b0;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit mr);
        for (int i = 0; i < n; i++) run_cycle(1'b0, '0, mr, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i <= LAT; i++) begin
            hpa[i]  = '0;
            hdrv[i] = 1'b0;
        end
        #1;
        repeat (2) run_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(8, 1'b1);

        // single word at cycle 10, then silent slots with three injections
        run_cycle(1'b1, DW'(1), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            run_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, (i == 0) || (i == 2) || (i == 8));

        // back-to-back stream
        for (int i = 0; i < 20; i++) run_cycle(1'b1, rand_word(), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(10, 1'b1);

        // full backpressure, then release
        for (int i = 0; i < 15; i++) run_cycle(1'b1, rand_word(), 1'b0, 1'b0, 1'b0, 1'b0);
        idle(20, 1'b1);

        // flush after three words
        for (int i = 0; i < 3; i++) run_cycle(1'b1, rand_word(), 1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(15, 1'b1);

        // flush while idle
        run_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b1);

        // reset with five words in flight
        for (int i = 0; i < 5; i++) run_cycle(1'b1, rand_word(), 1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(15, 1'b1);

        // random traffic with occasional flushes and silent-slot injections
        for (int i = 0; i < 500; i++)
            run_cycle($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 2) != 0,
                      $urandom_range(0, 59) == 0, 1'b0, $urandom_range(0, 9) == 0);
        idle(25, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
